// File: rtl/csi_packet_framer.sv
// CSI-2 packet framer: assembles the 4-byte packet header for ecc_block, decodes the
// corrected header, then frames long-packet payload bytes and the 2-byte CRC footer.
module csi_packet_framer #(
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sot,
  output logic [31:0] ph_raw,
  input  logic [23:0] ph_corr,
  input  logic        ecc_no_error,
  input  logic        ecc_corrected,
  input  logic        ecc_error,
  output logic        hdr_valid,
  output logic [5:0]  data_type,
  output logic [1:0]  vc,
  output logic [15:0] word_count,
  output logic        short_pkt,
  output logic        hdr_corrected,
  output logic        hdr_error,
  output logic        pay_valid,
  output logic [7:0]  pay_data,
  output logic        pay_last,
  output logic        crc_valid,
  output logic [15:0] crc_rx,
  output logic        aborted,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CRC} state_t;

  state_t      state, state_nx;
  logic [23:0] hdr_bytes;
  logic [1:0]  byte_cnt;
  logic [15:0] remaining;
  logic [7:0]  crc_lo;
  logic        sot, hdr_done, hdr_short;

  assign sot       = in_valid & in_sot;
  assign hdr_done  = (state == HDR) & in_valid & ~in_sot & (byte_cnt == 2'd3);
  assign hdr_short = ph_corr[5:0] <= SHORT_DT_MAX;
  // Byte 3 (the ECC byte) goes straight from the input to ecc_block.
  assign ph_raw    = {in_data, hdr_bytes};
  assign busy      = state != IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (sot) state_nx = HDR;
    else begin
      case (state)
        HDR: if (hdr_done) begin
          if (ecc_error || hdr_short) state_nx = IDLE;
          else if (ph_corr[23:8] == 16'd0) state_nx = CRC;
          else state_nx = PAYLOAD;
        end
        PAYLOAD: if (in_valid && remaining == 16'd1) state_nx = CRC;
        CRC:     if (in_valid && byte_cnt == 2'd1) state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_bytes     <= '0;
      byte_cnt      <= '0;
      remaining     <= '0;
      crc_lo        <= '0;
      hdr_valid     <= 1'b0;
      data_type     <= '0;
      vc            <= '0;
      word_count    <= '0;
      short_pkt     <= 1'b0;
      hdr_corrected <= 1'b0;
      hdr_error     <= 1'b0;
      pay_valid     <= 1'b0;
      pay_data      <= '0;
      pay_last      <= 1'b0;
      crc_valid     <= 1'b0;
      crc_rx        <= '0;
      aborted       <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      hdr_error <= 1'b0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      crc_valid <= 1'b0;
      aborted   <= 1'b0;
      if (sot) begin
        // A start-of-transmission always restarts header capture, dropping any open packet.
        hdr_bytes <= {in_data, 16'h0};
        byte_cnt  <= 2'd1;
        aborted   <= state != IDLE;
      end else if (in_valid) begin
        case (state)
          HDR: begin
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              if (ecc_error) hdr_error <= 1'b1;
              else begin
                hdr_valid     <= 1'b1;
                data_type     <= ph_corr[5:0];
                vc            <= ph_corr[7:6];
                word_count    <= ph_corr[23:8];
                short_pkt     <= hdr_short;
                hdr_corrected <= ecc_corrected & ~ecc_no_error;
                remaining     <= ph_corr[23:8];
              end
            end else begin
              hdr_bytes <= {in_data, hdr_bytes[23:8]};
              byte_cnt  <= byte_cnt + 2'd1;
            end
          end
          PAYLOAD: begin
            pay_valid <= 1'b1;
            pay_data  <= in_data;
            pay_last  <= remaining == 16'd1;
            remaining <= remaining - 16'd1;
          end
          CRC: begin
            if (byte_cnt == 2'd0) begin
              crc_lo   <= in_data;
              byte_cnt <= 2'd1;
            end else begin
              crc_rx    <= {in_data, crc_lo};
              crc_valid <= 1'b1;
              byte_cnt  <= 2'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csi_packet_framer.sv
// Scoreboard bench for csi_packet_framer with a behavioural CSI-2 header ECC decoder.
module tb_csi_packet_framer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_sot;
  logic [7:0]  in_data;
  logic [31:0] ph_raw;
  logic [23:0] ph_corr;
  logic        ecc_no_error, ecc_corrected, ecc_error;
  logic        hdr_valid, short_pkt, hdr_corrected, hdr_error;
  logic [5:0]  data_type;
  logic [1:0]  vc;
  logic [15:0] word_count, crc_rx;
  logic        pay_valid, pay_last, crc_valid, aborted, busy;
  logic [7:0]  pay_data;

  localparam logic [3:0] K_HDR = 4'd1, K_HERR = 4'd2, K_PAY = 4'd3, K_CRC = 4'd4, K_ABT = 4'd5;
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  int errs = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  csi_packet_framer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_sot(in_sot),
    .ph_raw(ph_raw), .ph_corr(ph_corr), .ecc_no_error(ecc_no_error),
    .ecc_corrected(ecc_corrected), .ecc_error(ecc_error), .hdr_valid(hdr_valid),
    .data_type(data_type), .vc(vc), .word_count(word_count), .short_pkt(short_pkt),
    .hdr_corrected(hdr_corrected), .hdr_error(hdr_error), .pay_valid(pay_valid),
    .pay_data(pay_data), .pay_last(pay_last), .crc_valid(crc_valid), .crc_rx(crc_rx),
    .aborted(aborted), .busy(busy));

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p = '0;
    for (int i = 0; i < 24; i++) if (d[i]) p = p ^ ECC_COL[i];
    return p;
  endfunction

  // Stand-in for ecc_block: single-bit correct, multi-bit detect.
  logic [5:0] syn;
  logic       hit;
  always_comb begin
    syn = ecc6(ph_raw[23:0]) ^ ph_raw[29:24];
    ph_corr = ph_raw[23:0];
    ecc_no_error = 1'b0; ecc_corrected = 1'b0; ecc_error = 1'b0; hit = 1'b0;
    if (syn == 6'h0) ecc_no_error = 1'b1;
    else if ($countones(syn) == 1) ecc_corrected = 1'b1;
    else begin
      for (int i = 0; i < 24; i++)
        if (ECC_COL[i] == syn) begin ph_corr[i] = ~ph_corr[i]; hit = 1'b1; end
      if (hit) ecc_corrected = 1'b1;
      else     ecc_error = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic got_ev(input string tag, input logic [31:0] v);
    logic [31:0] e;
    if (exp_q.size() == 0) chk({tag, "_unexpected"}, v, 32'hFFFF_FFFF);
    else begin
      e = exp_q.pop_front();
      chk(tag, v, e);
    end
  endtask

  always @(negedge clk) begin
    if (pay_valid) got_ev("pay", {K_PAY, 19'd0, pay_last, pay_data});
    if (hdr_valid) got_ev("hdr", {K_HDR, 2'd0, hdr_corrected, short_pkt, vc, data_type, word_count});
    if (hdr_error) got_ev("hdr_error", {K_HERR, 28'd0});
    if (crc_valid) got_ev("crc", {K_CRC, 12'd0, crc_rx});
    if (aborted)   got_ev("aborted", {K_ABT, 28'd0});
  end

  task automatic send(input logic [7:0] b, input logic s);
    @(negedge clk);
    in_valid = 1'b1; in_data = b; in_sot = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_sot = 1'b0; in_data = 8'h00;
    end
  endtask

  task automatic send_hdr(input logic [5:0] dt, input logic [1:0] v, input logic [15:0] wc,
                          input logic [31:0] flip);
    logic [23:0] d;
    logic [31:0] raw;
    d = {wc, v, dt};
    raw = {2'b00, ecc6(d), d} ^ flip;
    send(raw[7:0], 1'b1);
    send(raw[15:8], 1'b0);
    send(raw[23:16], 1'b0);
    send(raw[31:24], 1'b0);
  endtask

  task automatic exp_hdr(input logic [5:0] dt, input logic [1:0] v, input logic [15:0] wc,
                         input logic corr);
    exp_q.push_back({K_HDR, 2'd0, corr, dt <= 6'h0F, v, dt, wc});
  endtask

  task automatic exp_pay(input logic [7:0] b, input logic last);
    exp_q.push_back({K_PAY, 19'd0, last, b});
  endtask

  task automatic exp_crc(input logic [15:0] c);
    exp_q.push_back({K_CRC, 12'd0, c});
  endtask

  initial begin
    logic [7:0] pl [4];
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    reset = 1'b1; in_valid = 1'b0; in_sot = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_pulses", {26'd0, hdr_valid, hdr_error, pay_valid, pay_last, crc_valid, aborted}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fields", {8'd0, data_type, vc, word_count}, 32'd0);
    chk("rst_crc", {16'd0, crc_rx}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Short packet, all-zero header
    exp_hdr(6'h00, 2'd0, 16'h0000, 1'b0);
    send_hdr(6'h00, 2'd0, 16'h0000, 32'h0);
    idle(1);
    chk("short_hdr_latency", {31'd0, hdr_valid}, 32'd1);
    chk("short_busy", {31'd0, busy}, 32'd0);
    idle(3);

    // Long RAW8 packet, WC=4
    exp_hdr(6'h2A, 2'd1, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) exp_pay(pl[i], i == 3);
    exp_crc(16'hCDAB);
    send_hdr(6'h2A, 2'd1, 16'd4, 32'h0);
    for (int i = 0; i < 4; i++) send(pl[i], 1'b0);
    send(8'hAB, 1'b0); send(8'hCD, 1'b0);
    idle(1);
    chk("long_crc_rx", {16'd0, crc_rx}, 32'h0000CDAB);
    chk("long_busy", {31'd0, busy}, 32'd0);
    idle(3);

    // Single-bit header error (bit 3 of byte 0) gets corrected
    exp_hdr(6'h2A, 2'd0, 16'd4, 1'b1);
    for (int i = 0; i < 4; i++) exp_pay(pl[i] ^ 8'hF0, i == 3);
    exp_crc(16'h3412);
    send_hdr(6'h2A, 2'd0, 16'd4, 32'h0000_0008);
    for (int i = 0; i < 4; i++) send(pl[i] ^ 8'hF0, 1'b0);
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    idle(3);

    // Double-bit header error: packet dropped, trailing bytes ignored
    exp_q.push_back({K_HERR, 28'd0});
    send_hdr(6'h2A, 2'd0, 16'd4, 32'h0000_0003);
    for (int i = 0; i < 6; i++) send(8'h5A + 8'(i), 1'b0);
    idle(1);
    chk("herr_busy", {31'd0, busy}, 32'd0);
    idle(2);

    // Stall of 3 cycles between payload bytes 2 and 3
    exp_hdr(6'h2B, 2'd2, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) exp_pay(pl[i] + 8'h01, i == 3);
    exp_crc(16'h9988);
    send_hdr(6'h2B, 2'd2, 16'd4, 32'h0);
    send(pl[0] + 8'h01, 1'b0); send(pl[1] + 8'h01, 1'b0);
    idle(3);
    send(pl[2] + 8'h01, 1'b0); send(pl[3] + 8'h01, 1'b0);
    send(8'h88, 1'b0); idle(2); send(8'h99, 1'b0);
    idle(3);

    // Abort after payload byte 2, followed by a complete short packet
    exp_hdr(6'h2A, 2'd0, 16'd6, 1'b0);
    exp_pay(8'hA1, 1'b0); exp_pay(8'hA2, 1'b0);
    exp_q.push_back({K_ABT, 28'd0});
    exp_hdr(6'h01, 2'd3, 16'h1234, 1'b0);
    send_hdr(6'h2A, 2'd0, 16'd6, 32'h0);
    send(8'hA1, 1'b0); send(8'hA2, 1'b0);
    send_hdr(6'h01, 2'd3, 16'h1234, 32'h0);
    idle(1);
    chk("abort_short_busy", {31'd0, busy}, 32'd0);
    idle(3);

    // WC=0 long packet goes straight to the footer
    exp_hdr(6'h24, 2'd0, 16'd0, 1'b0);
    exp_crc(16'hBEEF);
    send_hdr(6'h24, 2'd0, 16'd0, 32'h0);
    send(8'hEF, 1'b0); send(8'hBE, 1'b0);
    idle(3);

    // Reset in the middle of a long packet
    exp_hdr(6'h2A, 2'd0, 16'd8, 1'b0);
    exp_pay(8'h01, 1'b0); exp_pay(8'h02, 1'b0);
    send_hdr(6'h2A, 2'd0, 16'd8, 32'h0);
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_wc", {16'd0, word_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_hdr(6'h02, 2'd1, 16'h00FF, 1'b0);
    send_hdr(6'h02, 2'd1, 16'h00FF, 32'h0);
    idle(5);

    chk("drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/csi_packet_framer.md
Name: csi_packet_framer

Overview:
- Sits directly upstream of ecc_block, fed by the lane-merged CSI-2 byte stream.
- Assembles the 4-byte packet header and drives ecc_block's 32-bit header input combinationally. Takes back the corrected 24-bit header and the status flags.
- Decodes data ID / word count, then frames long-packet payload bytes and the 2-byte CRC footer for downstream stages.
- Short packets end after the header; ECC-fatal headers drop the packet.

Parameters:
SHORT_DT_MAX, 6'h0F, largest data type treated as a short packet (no payload, no CRC)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  byte valid; no backpressure, gaps allowed
in_data  in  8  received byte
in_sot  in  1  qualifies in_data as first header byte (only meaningful with in_valid)
ph_raw  out  32  {ecc, wc_msb, wc_lsb, data_id} to ecc_block PH_in
ph_corr  in  24  corrected header from ecc_block
ecc_no_error  in  1  from ecc_block
ecc_corrected  in  1  from ecc_block
ecc_error  in  1  from ecc_block (uncorrectable)
hdr_valid  out  1  one-cycle pulse: header fields valid
data_type  out  6  ph_corr[5:0]
vc  out  2  ph_corr[7:6]
word_count  out  16  ph_corr[23:8]
short_pkt  out  1  data_type <= SHORT_DT_MAX
hdr_corrected  out  1  single-bit error was corrected
hdr_error  out  1  one-cycle pulse: uncorrectable header, packet dropped
pay_valid  out  1  payload byte strobe
pay_data  out  8  payload byte
pay_last  out  1  marks final payload byte
crc_valid  out  1  one-cycle pulse: footer captured
crc_rx  out  16  received CRC, first footer byte in [7:0]
aborted  out  1  one-cycle pulse: in_sot arrived mid-packet
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE. Every registered output, byte counters and header shift register go to 0.
- States:
  - IDLE: wait for in_valid&in_sot. Store byte 0, go to HDR. Bytes without in_sot are ignored.
  - HDR: collect bytes 1..3, accepting only on in_valid.
    - ph_raw = {in_data, hdr_bytes[23:0]}, combinational. It is only meaningful on the byte-3 cycle.
    - On the byte-3 edge, sample ph_corr and the ECC flags.
    - ecc_error: pulse hdr_error next cycle, no hdr_valid, go to IDLE.
    - Otherwise: register data_type, vc, word_count, short_pkt and hdr_corrected; pulse hdr_valid next cycle.
    - Short packet: go to IDLE.
    - Long packet with word_count==0: go to CRC.
    - Otherwise: go to PAYLOAD with remaining=word_count.
  - PAYLOAD: each accepted byte is emitted with pay_valid and pay_data one cycle later (1-cycle latency), and remaining decrements. pay_last is asserted with the byte accepted when remaining==1, then the state goes to CRC.
  - CRC: accept 2 bytes. On the 2nd, crc_rx={byte1,byte0} and crc_valid pulses next cycle; go to IDLE.
- No CRC computation here. ecc_no_error is informational only.
- Field outputs hold until the next hdr_valid; pulses last exactly one cycle.
- in_valid low in any state is a stall: no counter or state change.
- in_sot&in_valid in HDR/PAYLOAD/CRC:
  - Pulse aborted.
  - Drop the current packet: no pay_last, no crc_valid.
  - Treat the byte as header byte 0 and go to HDR.
  - A payload byte already in the output register still emits.
- word_count 0xFFFF: 16-bit remaining counter, no wrap; 65535 payload bytes exactly.
- Reset asserted mid-packet clears immediately; the partial packet is never completed.

Test Plan:
- Bench pairs the DUT with ecc_block, which supplies ph_corr and the flags.
- Short packet, header bytes 00,00,00,ECC, contiguous -> hdr_valid 1 cycle after byte 3; data_type 0x00, short_pkt=1, no pay_valid, busy=0 next cycle.
- Long packet RAW8 (0x2A, WC=4), payload 11,22,33,44, footer AB,CD -> 4 pay_valid, pay_last on 0x44; crc_valid with crc_rx=0xCDAB.
- Same long header with bit 3 of byte 0 flipped -> hdr_corrected=1, data_type=0x2A, payload framed normally.
- Two header bits flipped -> hdr_error pulse, no hdr_valid, following bytes ignored until next in_sot.
- WC=4 payload with in_valid low 3 cycles between bytes 2 and 3 -> still exactly 4 pay_valid in order; crc_valid after both footer bytes.
- in_sot after payload byte 2, then a full short packet -> aborted pulse, no pay_last/crc_valid for the first packet; the short packet decodes correctly.
- WC=0 long packet -> hdr_valid, then no payload, crc_valid after 2 footer bytes.
